// File: rtl/axa_pkg.sv
// Shared AXA core definitions: word width, operand source types,
// the opcodes that save the old destination to the undo stack, and
// the default undo stack depth.
package axa_pkg;

    localparam int WORD       = 16;
    localparam int UNDO_DEPTH = 256;

    // Operand source types (2-bit src field)
    localparam logic [1:0] SRC_REG  = 2'b00;
    localparam logic [1:0] SRC_I4   = 2'b01;
    localparam logic [1:0] SRC_ADDR = 2'b10;
    localparam logic [1:0] SRC_UNDO = 2'b11;

    // Destructive ops that push the old destination value
    localparam logic [3:0] OPlhi = 4'h1;
    localparam logic [3:0] OPllo = 4'h2;
    localparam logic [3:0] OPshr = 4'h5;
    localparam logic [3:0] OPor  = 4'h6;
    localparam logic [3:0] OPand = 4'h7;
    localparam logic [3:0] OPdup = 4'hA;

    // True when the ALU stage must save the old destination before executing op
    function automatic logic is_undo_push(input logic [3:0] op);
        return (op == OPlhi) || (op == OPllo) || (op == OPshr) ||
               (op == OPor)  || (op == OPand) || (op == OPdup);
    endfunction

endpackage

// File: rtl/undo_mem.sv
// Undo stack storage: one synchronous write port, two asynchronous
// read ports (top-of-stack for pop, indexed entry for peek).
module undo_mem
    import axa_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int DEPTH = UNDO_DEPTH,
    parameter int PTR_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr_top,
    output logic [WIDTH-1:0] rdata_top,
    input  logic [PTR_W-1:0] raddr_peek,
    output logic [WIDTH-1:0] rdata_peek
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port; contents are never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_top  = mem[raddr_top];
    assign rdata_peek = mem[raddr_peek];

endmodule

// File: rtl/undo_stack.sv
// Undo stack for the AXA core. Circular buffer with top pointer tp
// (top entry at tp-1). Pushing onto a full stack overwrites the oldest
// entry and sets the sticky lost flag. Push+pop together replaces the
// top entry in place. Pop results are registered; peek is combinational.
module undo_stack
    import axa_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int DEPTH = UNDO_DEPTH,
    parameter int PTR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_en,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_en,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic             pop_err,
    input  logic [3:0]       peek_idx,
    output logic [WIDTH-1:0] peek_data,
    output logic             peek_hit,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             lost
);

    logic [PTR_W-1:0] tp;
    logic [PTR_W:0]   cnt;
    logic             lost_q;
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W-1:0] peek_ptr;
    logic [PTR_W-1:0] waddr;
    logic [WIDTH-1:0] rd_top;
    logic [WIDTH-1:0] rd_peek;
    logic             do_pop;
    logic             mem_we;
    logic [WIDTH-1:0] pop_data_p1;
    logic             vld_p1;
    logic             err_p1;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (PTR_W+1)'(DEPTH));
    assign count    = cnt;
    assign lost     = lost_q;
    assign do_pop   = pop_en && !empty;
    assign top_ptr  = tp - PTR_W'(1);
    assign peek_ptr = top_ptr - PTR_W'(peek_idx);
    // A replace-top writes over the current top; any other push writes at tp
    assign waddr    = do_pop ? top_ptr : tp;
    assign mem_we   = push_en && !reset;

    undo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk        (clk),
        .we         (mem_we),
        .waddr      (waddr),
        .wdata      (push_data),
        .raddr_top  (top_ptr),
        .rdata_top  (rd_top),
        .raddr_peek (peek_ptr),
        .rdata_peek (rd_peek)
    );

    // Peek is valid only for live entries; dead slots read as zero
    assign peek_hit  = ({{(PTR_W+1){1'b0}}, peek_idx} < {4'b0000, cnt});
    assign peek_data = peek_hit ? rd_peek : '0;

    // Pointer, count, sticky flag and registered pop result (stage p1)
    always_ff @(posedge clk) begin
        if (reset) begin
            tp          <= '0;
            cnt         <= '0;
            lost_q      <= 1'b0;
            pop_data_p1 <= '0;
            vld_p1      <= 1'b0;
            err_p1      <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            if (push_en && do_pop) begin
                pop_data_p1 <= rd_top;
                vld_p1      <= 1'b1;
            end else if (push_en) begin
                tp     <= tp + PTR_W'(1);
                err_p1 <= pop_en;
                if (full) begin
                    lost_q <= 1'b1;
                end else begin
                    cnt <= cnt + (PTR_W+1)'(1);
                end
            end else if (pop_en) begin
                if (empty) begin
                    err_p1 <= 1'b1;
                end else begin
                    pop_data_p1 <= rd_top;
                    vld_p1      <= 1'b1;
                    tp          <= top_ptr;
                    cnt         <= cnt - (PTR_W+1)'(1);
                end
            end
        end
    end

    assign pop_data  = pop_data_p1;
    assign pop_valid = vld_p1;
    assign pop_err   = err_p1;

endmodule

// File: tb/tb_undo_stack.sv
// Bench for undo_stack: table of single-cycle vectors, then hand-written
// wrap-around and reset sequences. Pop outcomes go through a scoreboard
// queue filled when stimulus is driven and drained after the clock edge.
module tb_undo_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 256;
    localparam int PTR_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             push_en;
    logic [WIDTH-1:0] push_data;
    logic             pop_en;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic             pop_err;
    logic [3:0]       peek_idx;
    logic [WIDTH-1:0] peek_data;
    logic             peek_hit;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             lost;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          vld;
        bit          err;
        logic [15:0] data;
    } pop_exp_t;

    typedef struct {
        bit          push;
        logic [15:0] pd;
        bit          pop;
        logic [3:0]  pidx;
        int          cnt;
        bit          hit;
        logic [15:0] peek;
        bit          vld;
        bit          err;
        logic [15:0] pdat;
    } vec_t;

    pop_exp_t exp_q[$];
    vec_t     vecs[$];

    undo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .push_en   (push_en),
        .push_data (push_data),
        .pop_en    (pop_en),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .pop_err   (pop_err),
        .peek_idx  (peek_idx),
        .peek_data (peek_data),
        .peek_hit  (peek_hit),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .lost      (lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, queue the expected pop outcome, check it after the edge
    task automatic step(input bit pu, input logic [15:0] pd, input bit po,
                        input bit ev, input bit ee, input logic [15:0] ed);
        pop_exp_t e;
        push_en   = pu;
        push_data = pd;
        pop_en    = po;
        exp_q.push_back('{vld: ev, err: ee, data: ed});
        @(posedge clk);
        #1;
        push_en = 1'b0;
        pop_en  = 1'b0;
        e = exp_q.pop_front();
        chk("pop_valid", 32'(pop_valid), 32'(e.vld));
        chk("pop_err", 32'(pop_err), 32'(e.err));
        if (e.vld) chk("pop_data", 32'(pop_data), 32'(e.data));
    endtask

    initial begin
        reset     = 1'b1;
        push_en   = 1'b0;
        push_data = '0;
        pop_en    = 1'b0;
        peek_idx  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset count", 32'(count), 0);
        chk("reset empty", 32'(empty), 1);
        chk("reset full", 32'(full), 0);
        chk("reset lost", 32'(lost), 0);
        chk("reset pop_valid", 32'(pop_valid), 0);
        chk("reset pop_err", 32'(pop_err), 0);
        chk("reset pop_data", 32'(pop_data), 0);
        chk("reset peek_hit", 32'(peek_hit), 0);
        reset = 1'b0;

        //       push pd       pop pidx cnt hit peek     vld err pdat
        vecs.push_back('{1, 16'h1111, 0, 0, 1, 1, 16'h1111, 0, 0, 16'h0});
        vecs.push_back('{1, 16'h2222, 0, 0, 2, 1, 16'h2222, 0, 0, 16'h0});
        vecs.push_back('{1, 16'h3333, 0, 0, 3, 1, 16'h3333, 0, 0, 16'h0});
        vecs.push_back('{0, 16'h0000, 0, 2, 3, 1, 16'h1111, 0, 0, 16'h0});
        vecs.push_back('{0, 16'h0000, 0, 3, 3, 0, 16'h0000, 0, 0, 16'h0});
        vecs.push_back('{0, 16'h0000, 1, 0, 2, 1, 16'h2222, 1, 0, 16'h3333});
        vecs.push_back('{0, 16'h0000, 1, 0, 1, 1, 16'h1111, 1, 0, 16'h2222});
        vecs.push_back('{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 0, 16'h1111});
        vecs.push_back('{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 1, 16'h0});
        vecs.push_back('{1, 16'hAAAA, 1, 0, 1, 1, 16'hAAAA, 0, 1, 16'h0});
        vecs.push_back('{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 0, 16'hAAAA});
        vecs.push_back('{1, 16'h0005, 0, 0, 1, 1, 16'h0005, 0, 0, 16'h0});
        vecs.push_back('{1, 16'hBEEF, 1, 0, 1, 1, 16'hBEEF, 1, 0, 16'h0005});
        vecs.push_back('{0, 16'h0000, 1, 1, 0, 0, 16'h0000, 1, 0, 16'hBEEF});

        foreach (vecs[i]) begin
            peek_idx = vecs[i].pidx;
            step(vecs[i].push, vecs[i].pd, vecs[i].pop, vecs[i].vld, vecs[i].err, vecs[i].pdat);
            chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].cnt == 0));
            chk($sformatf("vec%0d peek_hit", i), 32'(peek_hit), 32'(vecs[i].hit));
            chk($sformatf("vec%0d peek_data", i), 32'(peek_data), 32'(vecs[i].peek));
            chk($sformatf("vec%0d lost", i), 32'(lost), 0);
        end

        // Wrap-around: DEPTH+2 pushes overwrite the two oldest entries
        peek_idx = 4'd0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0, 16'h0);
            if (i == DEPTH - 1) begin
                chk("full at DEPTH", 32'(full), 1);
                chk("no loss at DEPTH", 32'(lost), 0);
            end
        end
        chk("wrap full", 32'(full), 1);
        chk("wrap count", 32'(count), DEPTH);
        chk("wrap lost", 32'(lost), 1);
        chk("wrap peek0", 32'(peek_data), 257);
        peek_idx = 4'd15;
        #1;
        chk("wrap peek15", 32'(peek_data), 242);
        chk("wrap peek15 hit", 32'(peek_hit), 1);
        peek_idx = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'(257 - i));
        end
        chk("drain empty", 32'(empty), 1);
        chk("drain count", 32'(count), 0);
        chk("lost sticky", 32'(lost), 1);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'h0);

        // Reset coinciding with a push wins
        step(1'b1, 16'h0101, 1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b1, 16'h0202, 1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b1, 16'h0303, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("pre-reset count", 32'(count), 3);
        reset = 1'b1;
        step(1'b1, 16'h0404, 1'b1, 1'b0, 1'b0, 16'h0);
        reset = 1'b0;
        chk("rst+push count", 32'(count), 0);
        chk("rst+push empty", 32'(empty), 1);
        chk("rst+push lost", 32'(lost), 0);
        chk("rst+push pop_data", 32'(pop_data), 0);
        chk("rst+push peek_hit", 32'(peek_hit), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
